flux_sequencer: RTL and testbench
=================================

# flux_sequencer

Write-side counterpart of the flux sampler. It consumes a byte stream of interval/pulse opcodes, in the same encoding the sampler emits, and regenerates timed flux-reversal pulses on `wdata` while holding `wgate` asserted. It sits between the host-side opcode FIFO and the floppy write pads; pad inversion is done outside this block.

## Interface
Parameters:
- `TICK_DIV`, default 6: clocks per sample tick. Must be ≥ 2.
- `PULSE_WIDTH`, default 3: clocks `wdata` stays high per pulse. Must satisfy 1 ≤ `PULSE_WIDTH` < `TICK_DIV`.

Ports:
- `clock` in 1: system clock.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle strobe that begins a write. Ignored while `busy`.
- `stop_on_index` in 1: when high, a rising edge of `index` ends the write.
- `index` in 1: raw drive index. Asynchronous to `clock`.
- `opcode` in 8: next opcode byte.
- `opcode_valid` in 1: `opcode` is valid.
- `opcode_ack` out 1: one-cycle strobe; `opcode` is consumed this cycle.
- `wdata` out 1: active-high write pulse.
- `wgate` out 1: write gate.
- `busy` out 1: sequencer is not idle.
- `done` out 1: one-cycle strobe on normal termination.
- `underrun` out 1: sticky; set when the stream starves. Cleared by `start`.

## Operation
- Opcode format:
  - Bit 7 = PULSE.
  - Bits [6:0] = INTERVAL, in ticks, range 1..127.
  - INTERVAL == 0 means STOP, whatever the value of bit 7.
- FSM states are IDLE, FETCH and WAIT.
- IDLE:
  - On `start`: clear the prescaler and `underrun`, then go to FETCH.
  - `wgate` and `busy` rise the next cycle.
- FETCH (exactly one cycle):
  - If the index-stop flag is set: go to IDLE and pulse `done`. No ack is issued.
  - Else if `opcode_valid` is low: set `underrun`, go to IDLE. No `done`.
  - Else: assert `opcode_ack`.
    - If the opcode is STOP: go to IDLE and pulse `done`.
    - Otherwise: load the counter with INTERVAL, latch PULSE, go to WAIT.
- WAIT:
  - On each tick, decrement the counter.
  - On the tick where the counter goes 1→0, an event occurs. If PULSE was latched, fire the pulse stretcher. Then go to FETCH.
  - An opcode with PULSE = 0 only extends the interval. This covers gaps longer than 127 ticks.
- Prescaler:
  - Free-running while `busy`.
  - `tick` is asserted when the prescaler equals `TICK_DIV`-1.
- Index stop:
  - `index` passes through a 2-flop synchronizer.
  - A rising edge while `busy` and `stop_on_index` sets the stop flag.
  - The flag takes effect at the next FETCH. A pulse already scheduled completes first.
- Returning to IDLE:
  - `wgate` and `busy` fall the cycle after the transition.
  - A stretched `wdata` pulse still in progress runs to completion.

## Timing
- Reset values: state IDLE.
- Every output resets to 0: `wdata`, `wgate`, `busy`, `done`, `opcode_ack`, `underrun`.
- Reset asserted mid-write forces all of these low immediately, with no completion.
- Start sequence:
  - `start` is seen at cycle 0.
  - FETCH is at cycle 1.
  - The first tick is at cycle `TICK_DIV`.
- `wdata` rises 1 clock after the event tick and stays high exactly `PULSE_WIDTH` clocks.
- Pulse spacing: the rising-edge spacing between consecutive pulses equals the sum of the intervening INTERVALs × `TICK_DIV` clocks. There is zero drift provided no underrun occurs.
- FETCH always completes before the next tick, because `TICK_DIV` ≥ 2.
- Handshake: `opcode_ack` is asserted only in FETCH with `opcode_valid` high. `opcode` must be stable while valid. There is at most one ack per tick interval.
- Simultaneous events:
  - `start` arriving while `busy` is dropped.
  - An index edge in the same cycle as FETCH is applied at the following FETCH.

## Structure
- Package `flux_pkg` holds:
  - `F_BIT_PULSE` = 7;
  - `F_INTERVAL_MASK` = 7'h7F;
  - the FSM state typedef.
- The sampler is updated to import the same package.
- Sub-module `flux_pulse_stretcher` contains:
  - inputs `fire`, `clock`, `reset`;
  - output `wdata`;
  - an internal down-counter of `PULSE_WIDTH`.

## Test plan
- Stream 0x85, 0x83, 0x00 with `TICK_DIV`=6:
  - 2 acks, then a third ack and `done`;
  - `wdata` rising edges 18 clocks apart;
  - each pulse 3 clocks wide;
  - `underrun` = 0.
- Stream 0x7F, 0x81: exactly one pulse, 128 ticks (768 clocks) after the first event-aligned FETCH.
- `opcode_valid` dropped after the first opcode: `underrun`=1, `wgate` falls, `done` stays 0. A subsequent `start` clears `underrun`.
- `stop_on_index`=1 with an `index` edge mid-interval on the infinite stream 0x84:
  - the scheduled pulse fires;
  - no further ack;
  - `done` pulses;
  - `wgate` falls.
- `reset` driven low in the middle of a `wdata` pulse: every output is 0 the same cycle, and the FSM is IDLE after release.
- `start` strobed while `busy`: no effect on acks, the pulse schedule, or `underrun`.

Source files
------------

// File: rtl/flux_pkg.sv
// Shared definitions for the flux sampler and sequencer: opcode fields and FSM states.
package flux_pkg;

    localparam int         F_BIT_PULSE     = 7;
    localparam logic [6:0] F_INTERVAL_MASK = 7'h7F;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FETCH = 2'b01,
        ST_WAIT  = 2'b10
    } flux_state_t;

    // An interval of zero terminates the stream regardless of the pulse bit.
    function automatic logic is_stop(input logic [7:0] op);
        return ((op[6:0] & F_INTERVAL_MASK) == 7'd0);
    endfunction

endpackage

// File: rtl/flux_pulse_stretcher.sv
// Stretches a one-cycle fire strobe into a registered PULSE_WIDTH-clock wdata pulse.
module flux_pulse_stretcher #(
    parameter int PULSE_WIDTH = 3
) (
    input  logic clock,
    input  logic reset,
    input  logic fire,
    output logic wdata
);

    localparam int            CW = $clog2(PULSE_WIDTH + 1);
    localparam logic [CW-1:0] PW = CW'(PULSE_WIDTH);

    logic [CW-1:0] cnt_r;

    // Down-counter; wdata stays high while the previous count exceeded one.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_r <= {CW{1'b0}};
            wdata <= 1'b0;
        end else if (fire) begin
            cnt_r <= PW;
            wdata <= 1'b1;
        end else if (cnt_r != {CW{1'b0}}) begin
            cnt_r <= cnt_r - CW'(1);
            wdata <= (cnt_r > CW'(1));
        end else begin
            cnt_r <= cnt_r;
            wdata <= 1'b0;
        end
    end

endmodule

// File: rtl/flux_sequencer.sv
// Write-side flux sequencer: turns interval/pulse opcodes into timed wdata pulses under wgate.
module flux_sequencer
    import flux_pkg::*;
#(
    parameter int TICK_DIV    = 6,
    parameter int PULSE_WIDTH = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       stop_on_index,
    input  logic       index,
    input  logic [7:0] opcode,
    input  logic       opcode_valid,
    output logic       opcode_ack,
    output logic       wdata,
    output logic       wgate,
    output logic       busy,
    output logic       done,
    output logic       underrun
);

    localparam int             PSW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PSW-1:0] PRESC_LAST = PSW'(TICK_DIV - 1);

    flux_state_t    state_r, state_s;
    logic [PSW-1:0] presc_r;
    logic [6:0]     cnt_r;
    logic           pulse_r;
    logic           idx_meta_r, idx_sync_r, idx_prev_r;
    logic           stop_flag_r;
    logic           tick_s, rise_s;
    logic           ack_s, load_s, done_s, underrun_set_s, fire_s;

    assign tick_s     = (presc_r == PRESC_LAST);
    assign rise_s     = idx_sync_r & ~idx_prev_r;
    // Ack must coincide with consumption, so it is decoded straight from FETCH.
    assign opcode_ack = ack_s;

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_r <= ST_IDLE;
        else        state_r <= state_s;
    end

    // Next-state and per-cycle strobes.
    always_comb begin
        state_s        = state_r;
        ack_s          = 1'b0;
        load_s         = 1'b0;
        done_s         = 1'b0;
        underrun_set_s = 1'b0;
        fire_s         = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) state_s = ST_FETCH;
                else       state_s = ST_IDLE;
            end
            ST_FETCH: begin
                if (stop_flag_r) begin
                    done_s  = 1'b1;
                    state_s = ST_IDLE;
                end else if (!opcode_valid) begin
                    underrun_set_s = 1'b1;
                    state_s        = ST_IDLE;
                end else begin
                    ack_s = 1'b1;
                    if (is_stop(opcode)) begin
                        done_s  = 1'b1;
                        state_s = ST_IDLE;
                    end else begin
                        load_s  = 1'b1;
                        state_s = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (tick_s && (cnt_r == 7'd1)) begin
                    fire_s  = pulse_r;
                    state_s = ST_FETCH;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Tick prescaler, held at zero while idle so a write starts phase-aligned.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)                presc_r <= {PSW{1'b0}};
        else if (state_r == ST_IDLE) presc_r <= {PSW{1'b0}};
        else if (tick_s)           presc_r <= {PSW{1'b0}};
        else                       presc_r <= presc_r + PSW'(1);
    end

    // Interval counter and latched pulse bit.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_r   <= 7'd0;
            pulse_r <= 1'b0;
        end else if (load_s) begin
            cnt_r   <= opcode[6:0] & F_INTERVAL_MASK;
            pulse_r <= opcode[F_BIT_PULSE];
        end else if ((state_r == ST_WAIT) && tick_s && (cnt_r != 7'd0)) begin
            cnt_r   <= cnt_r - 7'd1;
            pulse_r <= pulse_r;
        end else begin
            cnt_r   <= cnt_r;
            pulse_r <= pulse_r;
        end
    end

    // Index synchronizer, edge detector and stop flag (consumed at the next FETCH).
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            idx_meta_r  <= 1'b0;
            idx_sync_r  <= 1'b0;
            idx_prev_r  <= 1'b0;
            stop_flag_r <= 1'b0;
        end else begin
            idx_meta_r <= index;
            idx_sync_r <= idx_meta_r;
            idx_prev_r <= idx_sync_r;
            if (state_r == ST_IDLE)        stop_flag_r <= 1'b0;
            else if (stop_on_index && rise_s) stop_flag_r <= 1'b1;
            else                           stop_flag_r <= stop_flag_r;
        end
    end

    // Registered status outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            busy     <= 1'b0;
            wgate    <= 1'b0;
            done     <= 1'b0;
            underrun <= 1'b0;
        end else begin
            busy  <= (state_s != ST_IDLE);
            wgate <= (state_s != ST_IDLE);
            done  <= done_s;
            if ((state_r == ST_IDLE) && start) underrun <= 1'b0;
            else if (underrun_set_s)           underrun <= 1'b1;
            else                               underrun <= underrun;
        end
    end

    flux_pulse_stretcher #(
        .PULSE_WIDTH (PULSE_WIDTH)
    ) u_stretcher (
        .clock (clock),
        .reset (reset),
        .fire  (fire_s),
        .wdata (wdata)
    );

endmodule

// File: tb/tb_flux_sequencer.sv
// Directed self-checking bench for flux_sequencer with a small opcode-FIFO model and pulse monitor.
module tb_flux_sequencer;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       stop_on_index = 1'b0;
    logic       index = 1'b0;
    logic [7:0] opcode;
    logic       opcode_valid;
    logic       opcode_ack, wdata, wgate, busy, done, underrun;

    flux_sequencer #(.TICK_DIV(6), .PULSE_WIDTH(3)) dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .stop_on_index (stop_on_index),
        .index         (index),
        .opcode        (opcode),
        .opcode_valid  (opcode_valid),
        .opcode_ack    (opcode_ack),
        .wdata         (wdata),
        .wgate         (wgate),
        .busy          (busy),
        .done          (done),
        .underrun      (underrun)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Opcode source: pops on each ack; infinite mode repeats stream[0].
    logic [7:0] stream [0:7];
    int         base = 0;
    int         slen = 0;
    logic       infinite = 1'b0;
    int         ack_cnt = 0;
    int         rel;
    always @(posedge clock) if (opcode_ack) ack_cnt <= ack_cnt + 1;
    assign rel = ack_cnt - base;
    always_comb begin
        opcode       = infinite ? stream[0] : stream[rel[2:0]];
        opcode_valid = infinite || (rel < slen);
    end

    // Pulse/done monitor sampled on the falling edge.
    logic wd_q = 1'b0;
    int   n_rise = 0, run = 0, last_width = 0, n_done = 0;
    int   rise_cyc [0:63];
    always @(negedge clock) begin
        wd_q <= wdata;
        if (wdata && !wd_q && n_rise < 64) begin
            rise_cyc[n_rise] <= cyc;
            n_rise <= n_rise + 1;
        end
        if (wdata) run <= run + 1;
        else if (run != 0) begin
            last_width <= run;
            run <= 0;
        end
        if (done) n_done <= n_done + 1;
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
    endtask

    task automatic do_start(output int s0);
        start = 1'b1;
        s0 = cyc;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int dcyc);
        dcyc = -1;
        for (int i = 0; i < budget; i++) begin
            if (done) begin
                dcyc = cyc;
                break;
            end
            step();
        end
    endtask

    int s0, a0, d0, r0, dc;

    initial begin
        for (int i = 0; i < 8; i++) stream[i] = 8'h00;

        // Reset state
        step();
        check("rst_outputs", {26'd0, wdata, wgate, busy, done, opcode_ack, underrun}, 32'd0);
        reset = 1'b1;
        step();
        check("post_rst_busy", busy, 32'd0);
        check("post_rst_ack", opcode_ack, 32'd0);

        // Stream 0x85, 0x83, 0x00
        stream[0] = 8'h85; stream[1] = 8'h83; stream[2] = 8'h00;
        base = ack_cnt; slen = 3;
        a0 = ack_cnt; d0 = n_done; r0 = n_rise;
        do_start(s0);
        check("t1_busy_c1", busy, 32'd1);
        check("t1_wgate_c1", wgate, 32'd1);
        check("t1_ack_c1", opcode_ack, 32'd1);
        wait_done(200, dc);
        check("t1_done_cycle", dc - s0, 32'd50);
        check("t1_busy_fall", busy, 32'd0);
        check("t1_wgate_fall", wgate, 32'd0);
        for (int i = 0; i < 5; i++) step();
        check("t1_acks", ack_cnt - a0, 32'd3);
        check("t1_dones", n_done - d0, 32'd1);
        check("t1_pulses", n_rise - r0, 32'd2);
        check("t1_first_rise", rise_cyc[r0] - s0, 32'd31);
        check("t1_spacing", rise_cyc[r0 + 1] - rise_cyc[r0], 32'd18);
        check("t1_width", last_width, 32'd3);
        check("t1_underrun", underrun, 32'd0);

        // Long gap 0x7F, 0x81, 0x00
        stream[0] = 8'h7F; stream[1] = 8'h81; stream[2] = 8'h00;
        base = ack_cnt; slen = 3;
        a0 = ack_cnt; r0 = n_rise;
        do_start(s0);
        wait_done(900, dc);
        check("t2_done_cycle", dc - s0, 32'd770);
        for (int i = 0; i < 5; i++) step();
        check("t2_pulses", n_rise - r0, 32'd1);
        check("t2_rise", rise_cyc[r0] - s0, 32'd769);
        check("t2_acks", ack_cnt - a0, 32'd3);

        // Underrun after one opcode, then a fresh start clears it
        stream[0] = 8'h82;
        base = ack_cnt; slen = 1;
        a0 = ack_cnt; d0 = n_done;
        do_start(s0);
        dc = -1;
        for (int i = 0; i < 100; i++) begin
            if (!busy) begin
                dc = cyc;
                break;
            end
            step();
        end
        check("t3_idle_cycle", dc - s0, 32'd14);
        check("t3_underrun", underrun, 32'd1);
        check("t3_wgate", wgate, 32'd0);
        step(); step();
        check("t3_no_done", n_done - d0, 32'd0);
        check("t3_acks", ack_cnt - a0, 32'd1);
        stream[0] = 8'h00;
        base = ack_cnt; slen = 1;
        do_start(s0);
        check("t3_underrun_clr", underrun, 32'd0);
        wait_done(20, dc);
        check("t3_stop_done", dc - s0, 32'd2);

        // Index stop on infinite 0x84
        do_reset();
        stream[0] = 8'h84; infinite = 1'b1; stop_on_index = 1'b1; index = 1'b0;
        a0 = ack_cnt; d0 = n_done; r0 = n_rise;
        do_start(s0);
        while ((cyc - s0) < 30) step();
        index = 1'b1;
        wait_done(100, dc);
        check("t4_done_cycle", dc - s0, 32'd50);
        check("t4_wgate", wgate, 32'd0);
        for (int i = 0; i < 5; i++) step();
        check("t4_acks", ack_cnt - a0, 32'd2);
        check("t4_pulses", n_rise - r0, 32'd2);
        check("t4_last_rise", rise_cyc[r0 + 1] - s0, 32'd49);
        check("t4_width", last_width, 32'd3);
        check("t4_dones", n_done - d0, 32'd1);
        infinite = 1'b0; stop_on_index = 1'b0; index = 1'b0;

        // Reset in the middle of a pulse
        do_reset();
        stream[0] = 8'h81; infinite = 1'b1;
        do_start(s0);
        dc = -1;
        for (int i = 0; i < 50; i++) begin
            if (wdata) begin
                dc = cyc;
                break;
            end
            step();
        end
        check("t5_pulse_seen", dc - s0, 32'd7);
        #1 reset = 1'b0;
        #1;
        check("t5_async_clear", {26'd0, wdata, wgate, busy, done, opcode_ack, underrun}, 32'd0);
        step();
        reset = 1'b1;
        step();
        check("t5_idle_ack", opcode_ack, 32'd0);
        step();
        check("t5_idle_busy", busy, 32'd0);
        check("t5_idle_wgate", wgate, 32'd0);
        infinite = 1'b0;

        // Start strobes while busy are ignored
        do_reset();
        stream[0] = 8'h83; stream[1] = 8'h82; stream[2] = 8'h00;
        base = ack_cnt; slen = 3;
        a0 = ack_cnt; r0 = n_rise;
        do_start(s0);
        dc = -1;
        for (int i = 1; i < 45; i++) begin
            start = ((i == 10) || (i == 19));
            if (done && dc < 0) dc = cyc - s0;
            step();
        end
        start = 1'b0;
        check("t6_done_cycle", dc, 32'd32);
        check("t6_acks", ack_cnt - a0, 32'd3);
        check("t6_pulses", n_rise - r0, 32'd2);
        check("t6_first_rise", rise_cyc[r0] - s0, 32'd19);
        check("t6_spacing", rise_cyc[r0 + 1] - rise_cyc[r0], 32'd12);
        check("t6_underrun", underrun, 32'd0);
        check("t6_busy", busy, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
